// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM-backed streaming FIFO controller.
package sram_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  // Words held in the registered output buffer behind the macro read port.
  localparam int OUT_BUF_DEPTH = 2;
  localparam int OUT_CNT_WIDTH = $clog2(OUT_BUF_DEPTH + 1);

endpackage

// File: rtl/sram_fifo_out_buf.sv
// Two-entry registered output buffer. Entry 0 is always the head, so
// pop_data comes straight from a flop. A capture and a pop may share a
// cycle; the controller never captures into a full buffer without a pop.
module sram_fifo_out_buf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     arst_n_in,
  input  logic                     clear_in,
  input  logic                     capture_valid,
  input  logic [DATA_WIDTH-1:0]    capture_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [DATA_WIDTH-1:0]    pop_data,
  output logic [OUT_CNT_WIDTH-1:0] out_cnt
);

  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop_fire;

  assign pop_valid = (out_cnt != '0);
  assign pop_data  = buf0;
  assign pop_fire  = pop_valid & pop_ready;

  // Shift-style buffer: pops move entry 1 into the head, captures fill the
  // first free slot (or the slot freed by a same-cycle pop).
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      buf0    <= '0;
      buf1    <= '0;
      out_cnt <= '0;
    end else if (clear_in) begin
      out_cnt <= '0;
    end else begin
      case ({capture_valid, pop_fire})
        2'b10: begin
          if (out_cnt == '0) buf0 <= capture_data;
          else               buf1 <= capture_data;
          out_cnt <= out_cnt + 1'b1;
        end
        2'b01: begin
          buf0    <= buf1;
          out_cnt <= out_cnt - 1'b1;
        end
        2'b11: begin
          if (out_cnt == OUT_CNT_WIDTH'(1)) begin
            buf0 <= capture_data;
          end else begin
            buf0 <= buf1;
            buf1 <= capture_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Streaming FIFO built on a 1r1w SRAM macro. Writes go straight to the
// macro, reads are issued ahead so the macro's one-cycle read latency is
// hidden behind a two-entry output buffer.
//
// Handshakes: a word moves on a port exactly in a cycle where valid and
// ready are both high at the rising edge. push_ready depends only on
// registered state; pop_valid/pop_data come from flops and stay stable
// until popped. clear_in overrides both ports for its cycle.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  clear_in,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT     = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [2:0]            OUT_BUF_LIMIT = 3'(OUT_BUF_DEPTH);

  logic [ADDR_WIDTH-1:0]    wr_ptr;
  logic [ADDR_WIDTH-1:0]    rd_ptr;
  logic [ADDR_WIDTH:0]      sram_cnt;
  logic                     rd_pending;
  logic [OUT_CNT_WIDTH-1:0] out_cnt;
  logic                     push_fire;
  logic                     pop_fire;
  logic                     issue;
  logic [2:0]               buf_after;

  assign full       = (count == DEPTH_CNT);
  assign empty      = (count == '0);
  assign push_ready = !full;
  assign push_fire  = push_valid & push_ready & !clear_in;
  assign pop_fire   = pop_valid & pop_ready & !clear_in;

  // Output-buffer occupancy once this cycle's pop and in-flight read settle;
  // a new read is only issued if its word is sure to have a slot.
  assign buf_after = {1'b0, out_cnt} + {2'b0, rd_pending} - {2'b0, pop_fire};
  assign issue     = (sram_cnt != '0) & (buf_after < OUT_BUF_LIMIT) & !clear_in;

  // Macro port drive is combinational from this cycle's handshake.
  always_comb begin
    sram_csb0  = !push_fire;
    sram_addr0 = wr_ptr;
    sram_din0  = push_data;
    sram_csb1  = !issue;
    sram_addr1 = rd_ptr;
  end

  // Pointers, occupancy counters and the read-pending flag.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sram_cnt   <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
    end else if (clear_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sram_cnt   <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
    end else begin
      if (push_fire) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
      if (issue)     rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      rd_pending <= issue;
      case ({push_fire, issue})
        2'b10:   sram_cnt <= sram_cnt + 1'b1;
        2'b01:   sram_cnt <= sram_cnt - 1'b1;
        default: ;
      endcase
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  sram_fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk           (clk),
    .arst_n_in     (arst_n_in),
    .clear_in      (clear_in),
    .capture_valid (rd_pending),
    .capture_data  (sram_dout1),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_data      (pop_data),
    .out_cnt       (out_cnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl with a behavioural 1r1w macro model alongside.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n_in = 1'b0;
  logic          clear_in = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic          pop_ready = 1'b0;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .clear_in   (clear_in),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // ---------------- scoreboard state ----------------
  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;
  logic          hold_valid = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- macro model ----------------
  logic [DW-1:0] mem [DEPTH];
  logic          rd_en_q = 1'b0;
  logic [AW-1:0] rd_addr_q = '0;

  always @(posedge clk) begin
    if (!sram_csb0 && !sram_csb1) begin
      vectors++;
      if (sram_addr0 == sram_addr1) begin
        miscompares++;
        $display("FAIL addr_collision: both ports at addr 0x%0h at %0t", sram_addr0, $time);
      end
    end
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    rd_en_q   <= !sram_csb1;
    rd_addr_q <= sram_addr1;
  end

  // Read data appears after the mid-cycle falling edge.
  always @(negedge clk) begin
    if (rd_en_q) sram_dout1 <= mem[rd_addr_q];
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!arst_n_in) begin
      exp_q.delete();
      model_cnt  = 0;
      hold_valid = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(model_cnt));
      chk("empty", 32'(empty), 32'(model_cnt == 0));
      chk("full", 32'(full), 32'(model_cnt == DEPTH));
      chk("push_ready", 32'(push_ready), 32'(model_cnt != DEPTH));
      chk("sram_cnt_bound", 32'(dut.sram_cnt <= (AW + 1)'(DEPTH)), 32'd1);
      if (hold_valid) begin
        chk("hold_valid", 32'(pop_valid), 32'd1);
        chk("hold_data", 32'(pop_data), 32'(hold_data));
      end
      if (clear_in) begin
        exp_q.delete();
        model_cnt  = 0;
        hold_valid = 1'b0;
      end else begin
        if (pop_valid && pop_ready) begin
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'(pop_valid), 32'd0);
          end else begin
            chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
          end
        end
        model_cnt  = model_cnt + int'(push_valid && model_cnt != DEPTH) - int'(pop_valid && pop_ready);
        hold_valid = pop_valid && !pop_ready;
        hold_data  = pop_data;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies one cycle of stimulus; an accepted push enters the expected queue.
  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    if (pv && model_cnt != DEPTH && !clear_in) exp_q.push_back(pd);
  endtask

  task automatic drain(input string name);
    int n = 0;
    drive(1'b0, '0, 1'b1);
    while (exp_q.size() != 0 && n < 1500) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_csb0", 32'(sram_csb0), 32'd1);
    chk("rst_csb1", 32'(sram_csb1), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    arst_n_in = 1'b1;

    // Three back-to-back words through an empty FIFO.
    drive(1'b1, 8'h11, 1'b1); tick(); chk("lat_e0", 32'(pop_valid), 32'd0);
    drive(1'b1, 8'h22, 1'b1); tick(); chk("lat_e1", 32'(pop_valid), 32'd0);
    drive(1'b1, 8'h33, 1'b1); tick(); chk("lat_e2", 32'(pop_valid), 32'd1);
    drive(1'b0, '0, 1'b1);    tick(); chk("b2b_e3", 32'(pop_valid), 32'd1);
    tick(); chk("b2b_e4", 32'(pop_valid), 32'd1);
    tick(); chk("b2b_e5", 32'(pop_valid), 32'd0);
    chk("b2b_empty", 32'(empty), 32'd1);

    // Fill to capacity with the consumer stalled, then overflow attempt.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'(DEPTH));
    chk("fill_push_ready", 32'(push_ready), 32'd0);
    drive(1'b1, 8'hEE, 1'b0);
    chk("fill_csb0", 32'(sram_csb0), 32'd1);
    tick();
    chk("overflow_count", 32'(count), 32'(DEPTH));
    drain("fill_drain");

    // Continuous streaming with pointer wrap.
    for (int i = 0; i < 3000; i++) begin
      drive(1'b1, 8'($urandom), 1'b1);
      tick();
      if (i >= 2) begin
        chk("stream_no_bubble", 32'(pop_valid), 32'd1);
        chk("stream_count", 32'(count), 32'd3);
      end
    end
    drain("stream_drain");

    // Random traffic with backpressure.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end
    drain("random_drain");

    // Synchronous clear with a read in flight.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    clear_in = 1'b1;
    drive(1'b1, 8'h77, 1'b1);
    tick();
    clear_in = 1'b0;
    chk("clear_count", 32'(count), 32'd0);
    chk("clear_empty", 32'(empty), 32'd1);
    chk("clear_pop_valid", 32'(pop_valid), 32'd0);
    drive(1'b1, 8'hA5, 1'b1);
    tick();
    drain("clear_a5");
    chk("clear_after_pop_valid", 32'(pop_valid), 32'd0);

    // Asynchronous reset in mid-stream.
    for (int i = 0; i < 500; i++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      tick();
    end
    chk("pre_reset_count", 32'(count), 32'd500);
    @(posedge clk);
    #3;
    drive(1'b0, '0, 1'b0);
    arst_n_in = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk);
    #2;
    arst_n_in = 1'b1;
    drive(1'b1, 8'h5A, 1'b1);
    tick();
    drain("reset_5a");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
